// File: rtl/chirp_orth_dds.sv
// Quadrature NCO with a quarter-wave sine table and a linear tuning-word sweep engine.
// Four-stage datapath (accumulate, phase offset, table lookup, sign apply), all gated by en.
module chirp_orth_dds #(
   parameter int PW = 32,
   parameter int DW = 12,
   parameter int AW = 13,
   parameter int SW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [PW-1:0] freq_start,
   input  logic [PW-1:0] freq_step,
   input  logic [SW-1:0] sweep_len,
   input  logic [PW-1:0] phase,
   input  logic          mode,
   input  logic          start,
   input  logic          stop,
   output logic [DW-1:0] sin,
   output logic [DW-1:0] cos,
   output logic          out_valid,
   output logic [PW-1:0] freq_now,
   output logic          busy,
   output logic          done
);

   localparam int N  = 1 << AW;
   localparam int QD = N / 4;
   localparam int A  = (1 << (DW - 1)) - 1;
   localparam logic [PW-1:0] QOFF = PW'(1) << (PW - 2);

   typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_t;

   // Elaboration-time sine via Taylor series; the angle never leaves the first quadrant.
   function automatic int q_val(input int k);
      real x, term, s;
      x = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(N);
      term = x;
      s    = x;
      for (int j = 1; j < 16; j++) begin
         term = -term * x * x / real'((2 * j) * (2 * j + 1));
         s    = s + term;
      end
      return $rtoi(real'(A) * s + 0.5);
   endfunction

   logic [DW-2:0] qtab [QD];
   for (genvar g = 0; g < QD; g++) begin : g_tab
      localparam logic [DW-2:0] QV = (DW-1)'(q_val(g));
      assign qtab[g] = QV;
   end

   state_t        state;
   logic [SW-1:0] cnt;
   logic [PW-1:0] acc;
   logic [AW-1:0] ph0, ph1;
   logic [DW-2:0] mag0, mag1;
   logic          neg0, neg1;
   logic [2:0]    vcnt;

   // Datapath: only the top AW bits of each offset phase are kept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         ph0       <= '0;
         ph1       <= AW'(1) << (AW - 2);
         mag0      <= '0;
         mag1      <= '0;
         neg0      <= 1'b0;
         neg1      <= 1'b0;
         sin       <= '0;
         cos       <= '0;
         vcnt      <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         acc  <= acc + freq_now;
         ph0  <= AW'((acc + phase) >> (PW - AW));
         ph1  <= AW'((acc + phase + QOFF) >> (PW - AW));
         // Odd quadrants read the table mirrored: N/4-1-k is the bitwise inverse of k.
         mag0 <= qtab[ph0[AW-3:0] ^ {(AW-2){ph0[AW-2]}}];
         mag1 <= qtab[ph1[AW-3:0] ^ {(AW-2){ph1[AW-2]}}];
         neg0 <= ph0[AW-1];
         neg1 <= ph1[AW-1];
         sin  <= neg0 ? DW'(-{1'b0, mag0}) : {1'b0, mag0};
         cos  <= neg1 ? DW'(-{1'b0, mag1}) : {1'b0, mag1};
         if (vcnt != 3'd4) vcnt <= vcnt + 3'd1;
         out_valid <= (vcnt >= 3'd3);
      end else begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         freq_now <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (!en) begin
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            freq_now <= freq_start;
         end else begin
            case (state)
               SWEEP: begin
                  if (cnt == SW'(1)) begin
                     done <= 1'b1;
                     if (mode) begin
                        freq_now <= freq_start;
                        cnt      <= sweep_len;
                     end else begin
                        freq_now <= freq_now + freq_step;
                        cnt      <= '0;
                        state    <= HOLD;
                        busy     <= 1'b0;
                     end
                  end else begin
                     freq_now <= freq_now + freq_step;
                     cnt      <= cnt - SW'(1);
                  end
               end
               default: begin
                  // IDLE tracks freq_start continuously; HOLD only reloads on a restart.
                  if (state == IDLE || start) freq_now <= freq_start;
                  if (start) begin
                     if (sweep_len == '0) begin
                        state <= HOLD;
                        done  <= 1'b1;
                     end else begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                        cnt   <= sweep_len;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_chirp_orth_dds.sv
// Self-checking bench for chirp_orth_dds against a full-wave sine and sweep-rule model.
module tb_chirp_orth_dds;

   localparam real PI = 3.14159265358979323846;
   localparam int  ST_IDLE = 0, ST_SWEEP = 1, ST_HOLD = 2;

   logic        clk = 1'b0;
   logic        rst_n, en, mode, start, stop;
   logic [31:0] freq_start, freq_step, phase;
   logic [23:0] sweep_len;
   logic [11:0] dut_sin, dut_cos;
   logic        out_valid, busy, done;
   logic [31:0] freq_now;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] m_acc, m_freq;
   logic [31:0] ph_q[$];
   int          m_nen, m_st, m_rem;
   logic        m_valid, m_done;

   chirp_orth_dds dut (
      .clk(clk), .rst_n(rst_n), .en(en), .freq_start(freq_start), .freq_step(freq_step),
      .sweep_len(sweep_len), .phase(phase), .mode(mode), .start(start), .stop(stop),
      .sin(dut_sin), .cos(dut_cos), .out_valid(out_valid), .freq_now(freq_now),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] ref_wave(input logic [31:0] p);
      int  i, r;
      real x;
      i = int'(p[31:19]);
      x = 2047.0 * $sin(2.0 * PI * (real'(i) + 0.5) / 8192.0);
      if (x >= 0.0) r = $rtoi(x + 0.5);
      else          r = -$rtoi(-x + 0.5);
      return 12'(r);
   endfunction

   task automatic model_update();
      if (!rst_n) begin
         m_acc = '0; ph_q.delete(); m_nen = 0; m_valid = 0; m_done = 0;
         m_freq = '0; m_st = ST_IDLE; m_rem = 0;
      end else if (!en) begin
         m_valid = 0; m_done = 0;
      end else begin
         ph_q.push_back(m_acc + phase);
         if (ph_q.size() > 3) void'(ph_q.pop_front());
         m_acc   = m_acc + m_freq;
         m_nen   = m_nen + 1;
         m_valid = (m_nen >= 4);
         m_done  = 0;
         if (stop) begin
            m_st = ST_IDLE; m_freq = freq_start;
         end else if (m_st == ST_SWEEP) begin
            if (m_rem == 1) begin
               m_done = 1;
               if (mode) begin m_freq = freq_start; m_rem = int'(sweep_len); end
               else begin m_freq = m_freq + freq_step; m_st = ST_HOLD; end
            end else begin
               m_freq = m_freq + freq_step; m_rem = m_rem - 1;
            end
         end else if (start) begin
            m_freq = freq_start;
            if (sweep_len == 24'd0) begin m_st = ST_HOLD; m_done = 1; end
            else begin m_st = ST_SWEEP; m_rem = int'(sweep_len); end
         end else if (m_st == ST_IDLE) begin
            m_freq = freq_start;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; en = 0; start = 0; stop = 0; mode = 0;
      freq_start = 32'h1234_5678; freq_step = 0; phase = 0; sweep_len = 0;
      step(); step();
      checks += 6;
      if (dut_sin !== 12'd0)   begin errors++; $display("FAIL reset_sin got=%0h want=0", dut_sin); end
      if (dut_cos !== 12'd0)   begin errors++; $display("FAIL reset_cos got=%0h want=0", dut_cos); end
      if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      if (freq_now !== 32'd0)  begin errors++; $display("FAIL reset_freq got=%0h want=0", freq_now); end
      rst_n = 1;
   endtask

   task automatic test_dc();
      freq_start = 0; phase = 0; en = 1;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (out_valid !== (c >= 3)) begin
            errors++; $display("FAIL dc_valid edge=%0d got=%b want=%b", c + 1, out_valid, c >= 3);
         end
         if (c >= 3) begin
            checks += 2;
            if (dut_sin !== 12'd1)    begin errors++; $display("FAIL dc_sin got=%0d want=1", dut_sin); end
            if (dut_cos !== 12'd2047) begin errors++; $display("FAIL dc_cos got=%0d want=2047", dut_cos); end
         end
      end
   endtask

   task automatic test_symmetry();
      freq_start = 32'h0008_0000; phase = 0;
      for (int c = 0; c < 8192 + 8; c++) begin
         step();
         if (m_valid) begin
            checks += 2;
            if (dut_sin !== ref_wave(ph_q[0])) begin
               errors++; $display("FAIL sym_sin n=%0d got=%0d want=%0d", c, dut_sin, ref_wave(ph_q[0]));
            end
            if (dut_cos !== ref_wave(ph_q[0] + 32'h4000_0000)) begin
               errors++; $display("FAIL sym_cos n=%0d got=%0d want=%0d", c, dut_cos, ref_wave(ph_q[0] + 32'h4000_0000));
            end
         end
      end
      for (int c = 0; c < 64; c++) begin
         if (c % 16 == 0) begin freq_start = $urandom; phase = $urandom; end
         step();
         checks += 2;
         if (dut_sin !== ref_wave(ph_q[0])) begin
            errors++; $display("FAIL rnd_sin n=%0d got=%0d want=%0d", c, dut_sin, ref_wave(ph_q[0]));
         end
         if (dut_cos !== ref_wave(ph_q[0] + 32'h4000_0000)) begin
            errors++; $display("FAIL rnd_cos n=%0d got=%0d want=%0d", c, dut_cos, ref_wave(ph_q[0] + 32'h4000_0000));
         end
      end
   endtask

   task automatic test_single_sweep();
      int nb, nd;
      freq_start = 32'h0010_0000; freq_step = 32'h0000_1000; sweep_len = 100; mode = 0; phase = 0;
      step();
      start = 1; step(); start = 0;
      nb = busy ? 1 : 0; nd = done ? 1 : 0;
      for (int c = 0; c < 110; c++) begin
         step();
         if (busy) nb++;
         if (done) nd++;
         checks++;
         if (freq_now !== m_freq) begin
            errors++; $display("FAIL sweep_freq c=%0d got=%0h want=%0h", c, freq_now, m_freq);
         end
      end
      checks += 4;
      if (nb != 100) begin errors++; $display("FAIL sweep_busy_cycles got=%0d want=100", nb); end
      if (nd != 1)   begin errors++; $display("FAIL sweep_done_count got=%0d want=1", nd); end
      if (freq_now !== 32'h0010_0000 + 32'd409600) begin
         errors++; $display("FAIL sweep_hold_freq got=%0h want=%0h", freq_now, 32'h0010_0000 + 32'd409600);
      end
      if (dut_sin !== ref_wave(ph_q[0])) begin
         errors++; $display("FAIL sweep_sin got=%0d want=%0d", dut_sin, ref_wave(ph_q[0]));
      end
   endtask

   task automatic test_repeat();
      int nd;
      freq_start = 32'h0020_0000; freq_step = 32'h0000_0100; sweep_len = 5; mode = 1;
      start = 1; step(); start = 0;
      nd = 0;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (done) nd++;
         checks += 2;
         if (done !== m_done) begin errors++; $display("FAIL rep_done c=%0d got=%b want=%b", c, done, m_done); end
         if (freq_now !== m_freq) begin
            errors++; $display("FAIL rep_freq c=%0d got=%0h want=%0h", c, freq_now, m_freq);
         end
      end
      checks++;
      if (nd != 3) begin errors++; $display("FAIL rep_done_count got=%0d want=3", nd); end
      step(); step();
      stop = 1; step(); stop = 0;
      step();
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b want=0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL stop_done got=%b want=0", done); end
      if (freq_now !== 32'h0020_0000) begin
         errors++; $display("FAIL stop_freq got=%0h want=00200000", freq_now);
      end
      start = 1; stop = 1; step(); start = 0; stop = 0;
      step();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL collide_busy got=%b want=0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL collide_done got=%b want=0", done); end
      sweep_len = 0; freq_start = 32'h0030_0000;
      start = 1; step(); start = 0;
      checks += 3;
      if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b want=1", done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b want=0", busy); end
      if (freq_now !== 32'h0030_0000) begin errors++; $display("FAIL zero_freq got=%0h want=00300000", freq_now); end
      freq_start = 32'h0040_0000;
      step(); step();
      checks += 2;
      if (done !== 1'b0) begin errors++; $display("FAIL zero_done_once got=%b want=0", done); end
      if (freq_now !== 32'h0030_0000) begin errors++; $display("FAIL hold_frozen got=%0h want=00300000", freq_now); end
   endtask

   task automatic test_enable_wrap();
      freq_start = 32'h0100_0000; freq_step = 32'h0001_0000; sweep_len = 20; mode = 0; phase = $urandom;
      start = 1; step(); start = 0;
      for (int c = 0; c < 5; c++) step();
      for (int c = 0; c < 30; c++) begin
         en = ($urandom_range(0, 1) == 1);
         step();
         checks += 5;
         if (freq_now !== m_freq) begin errors++; $display("FAIL en_freq c=%0d got=%0h want=%0h", c, freq_now, m_freq); end
         if (busy !== (m_st == ST_SWEEP)) begin errors++; $display("FAIL en_busy c=%0d got=%b", c, busy); end
         if (out_valid !== m_valid) begin errors++; $display("FAIL en_valid c=%0d got=%b want=%b", c, out_valid, m_valid); end
         if (dut_sin !== ref_wave(ph_q[0])) begin
            errors++; $display("FAIL en_sin c=%0d got=%0d want=%0d", c, dut_sin, ref_wave(ph_q[0]));
         end
         if (done !== m_done) begin errors++; $display("FAIL en_done c=%0d got=%b want=%b", c, done, m_done); end
      end
      en = 1;
      stop = 1; step(); stop = 0;
      freq_start = 32'h7FFF_F000; freq_step = 32'h0000_1000; sweep_len = 2;
      step();
      start = 1; step(); start = 0;
      step();
      checks++;
      if (freq_now !== 32'h8000_0000) begin errors++; $display("FAIL wrap_first got=%0h want=80000000", freq_now); end
      step();
      checks += 2;
      if (freq_now !== 32'h8000_1000) begin errors++; $display("FAIL wrap_hold got=%0h want=80001000", freq_now); end
      if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy got=%b want=0", busy); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         en    = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 9) == 0);
         stop  = ($urandom_range(0, 29) == 0);
         mode  = $urandom_range(0, 1);
         sweep_len = 24'($urandom_range(1, 6));
         if ($urandom_range(0, 7) == 0) begin
            freq_start = $urandom; freq_step = $urandom; phase = $urandom;
         end
         step();
         checks += 6;
         if (freq_now !== m_freq) begin errors++; $display("FAIL rnd_freq c=%0d got=%0h want=%0h", c, freq_now, m_freq); end
         if (busy !== (m_st == ST_SWEEP)) begin errors++; $display("FAIL rnd_busy c=%0d got=%b", c, busy); end
         if (done !== m_done) begin errors++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, done, m_done); end
         if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, out_valid, m_valid); end
         if (dut_sin !== ref_wave(ph_q[0])) begin
            errors++; $display("FAIL rnd_s c=%0d got=%0d want=%0d", c, dut_sin, ref_wave(ph_q[0]));
         end
         if (dut_cos !== ref_wave(ph_q[0] + 32'h4000_0000)) begin
            errors++; $display("FAIL rnd_c c=%0d got=%0d want=%0d", c, dut_cos, ref_wave(ph_q[0] + 32'h4000_0000));
         end
      end
      start = 0; stop = 0; en = 1;
   endtask

   task automatic test_reset_mid();
      stop = 1; step(); stop = 0;
      freq_start = 32'h0010_0000; freq_step = 32'h0000_1000; sweep_len = 100; mode = 0;
      step();
      start = 1; step(); start = 0;
      for (int c = 0; c < 49; c++) step();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b want=1", busy); end
      rst_n = 0; step(); rst_n = 1;
      checks += 6;
      if (dut_sin !== 12'd0)  begin errors++; $display("FAIL mid_sin got=%0h want=0", dut_sin); end
      if (dut_cos !== 12'd0)  begin errors++; $display("FAIL mid_cos got=%0h want=0", dut_cos); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b want=0", out_valid); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
      if (done !== 1'b0)      begin errors++; $display("FAIL mid_done got=%b want=0", done); end
      if (freq_now !== 32'd0) begin errors++; $display("FAIL mid_freq got=%0h want=0", freq_now); end
      step();
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_after got=%b want=0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b want=0", busy); end
      if (freq_now !== 32'h0010_0000) begin errors++; $display("FAIL mid_idle_freq got=%0h want=00100000", freq_now); end
   endtask

   initial begin
      test_reset();
      test_dc();
      test_symmetry();
      test_single_sweep();
      test_repeat();
      test_enable_wrap();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
